// File: rtl/alu_pkg.sv
// Shared types and constants for the handshaked ALU.
package alu_pkg;

    // Operation select; encodings 12-15 are illegal and produce a zero result.
    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpXor  = 4'd2,
        OpAnd  = 4'd3,
        OpOr   = 4'd4,
        OpNor  = 4'd5,
        OpSlt  = 4'd6,
        OpSltu = 4'd7,
        OpSll  = 4'd8,
        OpSrl  = 4'd9,
        OpSra  = 4'd10,
        OpMul  = 4'd11
    } alu_op_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

    typedef enum logic {
        StIdle    = 1'b0,
        StMulBusy = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// done is asserted during the cycle whose edge retires the last bit; product
// already includes that final partial product so the caller can load it then.
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == SHW'(WIDTH - 1));
    assign product  = acc_next;

    // Next-state: load operands on start, otherwise retire one bit per cycle.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Multiplier state registers; reset aborts any running product.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus a multi-cycle MUL.
// Results sit in an output register until the consumer takes them.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             ovf,
    output logic             carry
);

    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             carry_q, carry_d;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_r;
    logic             alu_ovf;
    logic             alu_carry;

    // Reset forces in_ready low so nothing is accepted on the reset edge.
    assign in_ready  = !reset && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OpMul);
    assign mul_start = accept && is_mul;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shamt    = b[SHW-1:0];

    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign zero      = (r_q == '0);
    assign ovf       = ovf_q;
    assign carry     = carry_q;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result and flags; illegal encodings fall through to zeros.
    always_comb begin
        alu_r     = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        if (op <= OP_LAST_LEGAL) begin
            case (alu_op_e'(op))
                OpAdd: begin
                    alu_r     = sum_ext[WIDTH-1:0];
                    alu_carry = sum_ext[WIDTH];
                    alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
                end
                OpSub: begin
                    alu_r     = diff_ext[WIDTH-1:0];
                    // The extended difference goes negative exactly when a <u b.
                    alu_carry = diff_ext[WIDTH];
                    alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
                end
                OpXor:  alu_r = a ^ b;
                OpAnd:  alu_r = a & b;
                OpOr:   alu_r = a | b;
                OpNor:  alu_r = ~(a | b);
                OpSlt:  alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                OpSltu: alu_r = {{(WIDTH-1){1'b0}}, (a < b)};
                OpSll:  alu_r = a << shamt;
                OpSrl:  alu_r = a >> shamt;
                OpSra:  alu_r = $signed(a) >>> shamt;
                default: begin
                    alu_r     = '0;
                    alu_ovf   = 1'b0;
                    alu_carry = 1'b0;
                end
            endcase
        end
    end

    // Sequencer next-state: drain, accept, and MUL completion.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        ovf_d       = ovf_q;
        carry_d     = carry_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (is_mul) begin
                state_d = StMulBusy;
            end else begin
                r_d         = alu_r;
                ovf_d       = alu_ovf;
                carry_d     = alu_carry;
                out_valid_d = 1'b1;
            end
        end
        if ((state_q == StMulBusy) && mul_done) begin
            r_d         = mul_product[WIDTH-1:0];
            ovf_d       = |mul_product[2*WIDTH-1:WIDTH];
            carry_d     = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StIdle;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            ovf_q       <= ovf_d;
            carry_q     <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with an expected-result scoreboard.
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         zero;
    logic         ovf;
    logic         carry;

    typedef struct {
        logic [W-1:0] r;
        logic         ovf;
        logic         carry;
        string        name;
    } exp_t;

    exp_t q[$];
    exp_t pend;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    logic s_ov, s_ir, s_acc;
    logic [W-1:0] s_r;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .zero      (zero),
        .ovf       (ovf),
        .carry     (carry)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model, written with 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input string nm);
        exp_t m;
        logic [63:0] ux, uy, t, sx, sy, ss;
        ux = {32'b0, x};
        uy = {32'b0, y};
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        m.r = '0; m.ovf = 1'b0; m.carry = 1'b0; m.name = nm;
        case (o)
            4'd0: begin
                t = ux + uy; m.r = t[31:0]; m.carry = t[32];
                ss = sx + sy; m.ovf = (ss != {{32{ss[31]}}, ss[31:0]});
            end
            4'd1: begin
                t = ux - uy; m.r = t[31:0]; m.carry = (ux < uy);
                ss = sx - sy; m.ovf = (ss != {{32{ss[31]}}, ss[31:0]});
            end
            4'd2: m.r = x ^ y;
            4'd3: m.r = x & y;
            4'd4: m.r = x | y;
            4'd5: m.r = ~(x | y);
            4'd6: m.r = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd7: m.r = (ux < uy) ? 32'd1 : 32'd0;
            4'd8: begin t = ux << y[4:0]; m.r = t[31:0]; end
            4'd9: begin t = ux >> y[4:0]; m.r = t[31:0]; end
            4'd10: begin t = sx >> y[4:0]; m.r = t[31:0]; end
            4'd11: begin t = ux * uy; m.r = t[31:0]; m.ovf = |t[63:32]; end
            default: ;
        endcase
        return m;
    endfunction

    // One clock: sample mid-cycle, update scoreboard, then cross the edge.
    task automatic tick();
        exp_t e;
        #1;
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_r   = r;
        s_acc = in_valid && in_ready;
        if (s_acc) q.push_back(pend);
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                chk("spurious_output", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk({e.name, "_r"}, 64'(r), 64'(e.r));
                chk({e.name, "_zero"}, 64'(zero), 64'(e.r == '0));
                chk({e.name, "_ovf"}, 64'(ovf), 64'(e.ovf));
                chk({e.name, "_carry"}, 64'(carry), 64'(e.carry));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string nm);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        pend = model(o, x, y, nm);
        n = 0;
        s_acc = 1'b0;
        while (!s_acc && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_accepted"}, 64'(s_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    // Count busy cycles after a MUL accept until its result appears.
    task automatic wait_result(output int busy, output logic seen);
        busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (s_ov) seen = 1'b1;
            else if (!s_ir) busy++;
        end
    endtask

    initial begin
        int   busy;
        logic seen;
        int   n0;

        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        pend = model(4'd0, '0, '0, "none");
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
        chk("add_latency", 64'(out_valid), 64'd1);
        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_carry");
        issue(4'd1, 32'd3, 32'd5, "sub_neg");
        issue(4'd1, 32'h8000_0000, 32'd1, "sub_ovf");
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, "slt");
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, "sltu");
        issue(4'd10, 32'h8000_0000, 32'h21, "sra");
        issue(4'd8, 32'h1234_5678, 32'h20, "sll_zero_shift");
        issue(4'd5, 32'h0F0F_0000, 32'h0000_00F0, "nor");
        tick();

        issue(4'd11, 32'h0001_0000, 32'h0001_0000, "mul_big");
        a = $urandom; b = $urandom;
        wait_result(busy, seen);
        chk("mul_big_seen", 64'(seen), 64'd1);
        chk("mul_big_busy_cycles", 64'(busy), 64'd32);
        issue(4'd11, 32'd7, 32'd6, "mul_small");
        wait_result(busy, seen);
        chk("mul_small_seen", 64'(seen), 64'd1);
        chk("mul_small_busy_cycles", 64'(busy), 64'd32);

        // Back-pressure: result held, new XOR waits, then replaces it.
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2, "add_held");
        op = 4'd2; a = 32'h0000_F0F0; b = 32'h0000_0FF0; in_valid = 1'b1;
        pend = model(4'd2, a, b, "xor_after_hold");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_in_ready", 64'(s_ir), 64'd0);
            chk("hold_out_valid", 64'(s_ov), 64'd1);
            chk("hold_r", 64'(s_r), 64'd3);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("replace_out_valid", 64'(out_valid), 64'd1);
        chk("replace_r", 64'(r), 64'h0000_FF00);
        tick();

        // Reset in the middle of a MUL drops it.
        issue(4'd11, 32'd3, 32'd5, "mul_aborted");
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        chk("midrst_in_ready", 64'(s_ir), 64'd0);
        reset = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_r", 64'(r), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd1);
        chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
        issue(4'd0, 32'd2, 32'd2, "add_after_rst");

        issue(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "illegal");
        chk("illegal_latency", 64'(out_valid), 64'd1);
        tick();

        // Back-to-back single-cycle stream.
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(0, 10)); a = $urandom; b = $urandom; in_valid = 1'b1;
            pend = model(op, a, b, "stream");
            tick();
            chk("stream_accept", 64'(s_acc), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_outputs", 64'(n_out - n0), 64'd8);
        tick();
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
